eval_combine: RTL
=================

Name: eval_combine

Overview:
- Downstream of the polynomial evaluation engine when the polynomial is split into D_SPLIT chunks of M/D_SPLIT coefficients each.
- Consumes one 32*T-bit evaluation vector per chunk, delivered highest chunk first.
- Combines the chunks by Horner's rule in the degree-4 extension field: result_t = sum_j e_j,t * w_t^j, where w_t = r_t^(M/D_SPLIT) is supplied by the caller.
- Multiplication goes through the shared 32-bit extension-field multiplier port. Addition is done internally.

Parameters:
- FIELD, "P251", base field; "P251" or "GF256".
- T, 4, number of evaluation points (32-bit extension elements per vector).
- D_SPLIT, 2, number of chunks to combine; legal range 1..8.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a combine; latches i_rpow.
- i_rpow  in  32*T  w_t; element t at bits [32t+31:32t].
- i_eval  in  32*T  chunk evaluation vector, same packing as i_rpow.
- i_eval_valid  in  1  one-cycle pulse; i_eval valid this cycle.
- o_ready  out  1  high when an i_eval_valid pulse is accepted.
- o_start_mul  out  1  one-cycle pulse to the shared multiplier.
- o_x_mul  out  32  multiplier operand x = acc_t.
- o_y_mul  out  32  multiplier operand y = w_t.
- i_o_mul  in  32  multiplier product.
- i_done_mul  in  1  product valid pulse; latency is arbitrary, at least 1.
- o_result  out  32*T  combined evaluations.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, accumulators 0, chunk counter 0.
- States: IDLE, WAIT_EVAL, MUL_ISSUE, MUL_WAIT, ADD, DONE.
- IDLE:
  - On i_start: latch i_rpow, clear chunk counter, go to WAIT_EVAL.
  - o_result holds its previous value until the next i_start.
  - i_start is ignored in every state other than IDLE.
- WAIT_EVAL:
  - o_ready=1 only in this state.
  - i_eval_valid in any other state is dropped; no error flag.
  - On i_eval_valid, first chunk (counter==0): acc <= i_eval, counter++. If D_SPLIT==1 go to DONE, else stay.
  - On i_eval_valid, later chunk: latch i_eval into the pending register, set t=0, go to MUL_ISSUE.
- MUL_ISSUE: o_start_mul=1 for exactly one cycle with o_x_mul=acc_t and o_y_mul=w_t; go to MUL_WAIT.
- MUL_WAIT:
  - Operands are held stable until i_done_mul.
  - On i_done_mul, capture i_o_mul and go to ADD.
  - A done pulse arriving in any other state is ignored.
- ADD (one cycle): acc_t <= add(product, pending_t).
  - If t<T-1: t++, go to MUL_ISSUE.
  - Else counter++. Go to DONE if counter==D_SPLIT, otherwise back to WAIT_EVAL.
- DONE: o_result <= acc and o_done=1 for one cycle in the same transition; return to IDLE.
- Adder rules:
  - GF256: bitwise XOR of 32 bits.
  - P251: each byte independently computes (a+b) mod 251. This needs a 9-bit sum; subtract 251 when sum>=251.
  - Inputs are canonical (<251). Behaviour for non-canonical bytes is undefined.
- Latency:
  - D_SPLIT==1: o_done 2 cycles after the accepted i_eval_valid.
  - Otherwise, per later chunk: T*(2+Lmul) cycles after acceptance, where Lmul is the i_start-to-done multiplier latency. Add 1 cycle for the DONE transition.
- Chunk order is fixed: e_{D_SPLIT-1} first, e_0 last.
- Simultaneous i_start with reset deasserting: i_start is honoured only if sampled while i_rst_n=1.

Test Plan:
- GF256, T=4, D=2, w_t=32'h00000001, e1={32'h12345678, 32'h33223322, 32'h22222222, 32'h0}, e0 all 32'hFFFFFFFF -> o_result = elementwise e1 XOR 32'hFFFFFFFF; exactly 4 o_start_mul pulses.
- P251, T=4, D=2, w=1, e1 element0=32'hFA000000, e0 element0=32'h05000000 -> element0 = 32'h04000000 (250+5 mod 251 = 4); remaining elements 0.
- P251, D=2, w_t=0, arbitrary e1, e0=32'h01020304 per element -> o_result equals e0 exactly.
- D=1, single i_eval_valid with 32'hDEADBEEF per element -> o_result identical; o_done 2 cycles later; no o_start_mul.
- Multiplier model with latencies 1 and 7, D=3 -> identical results; o_x_mul/o_y_mul stable through each wait; i_eval_valid sent mid-multiply is ignored and o_ready=0.
- Assert i_rst_n=0 during MUL_WAIT -> all outputs 0 immediately; next i_start runs a fresh combine correctly.

Source files
------------

// File: rtl/eval_combine_if.sv
// Handshake and data bundle between eval_combine, its caller and the shared extension-field multiplier.
interface eval_combine_if #(
  parameter int T = 4
);
  logic            i_start;
  logic [32*T-1:0] i_rpow;
  logic [32*T-1:0] i_eval;
  logic            i_eval_valid;
  logic            o_ready;
  logic            o_start_mul;
  logic [31:0]     o_x_mul;
  logic [31:0]     o_y_mul;
  logic [31:0]     i_o_mul;
  logic            i_done_mul;
  logic [32*T-1:0] o_result;
  logic            o_done;

  modport slave (
    input  i_start, i_rpow, i_eval, i_eval_valid, i_o_mul, i_done_mul,
    output o_ready, o_start_mul, o_x_mul, o_y_mul, o_result, o_done
  );

  modport master (
    output i_start, i_rpow, i_eval, i_eval_valid, i_o_mul, i_done_mul,
    input  o_ready, o_start_mul, o_x_mul, o_y_mul, o_result, o_done
  );
endinterface

// File: rtl/eval_combine.sv
// Horner-combines D_SPLIT chunk evaluations (highest chunk first) through the shared multiplier port.
// Each later chunk costs T*(2+Lmul) cycles; o_ready is high only in WAIT_EVAL and evals offered elsewhere are dropped.
module eval_combine #(
  parameter string FIELD   = "P251",
  parameter int    T       = 4,
  parameter int    D_SPLIT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  eval_combine_if.slave bus
);
  localparam bit IS_GF = (FIELD == "GF256");
  localparam int CW    = $clog2(D_SPLIT + 1);
  localparam int TW    = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(D_SPLIT - 1);
  localparam logic [TW-1:0] LAST_T     = TW'(T - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EVAL = 3'd1,
    MUL_ISSUE = 3'd2,
    MUL_WAIT  = 3'd3,
    ADD       = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     acc_q  [T];
  logic [31:0]     w_q    [T];
  logic [31:0]     pend_q [T];
  logic [31:0]     prod_q;
  logic [TW-1:0]   t_q;
  logic [CW-1:0]   cnt_q;
  logic [32*T-1:0] result_q;
  logic            done_q;

  // P251 adds each byte modulo 251 independently; GF256 addition is a plain XOR.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [8:0]  s;
    r = a ^ b;
    if (!IS_GF) begin
      for (int i = 0; i < 4; i++) begin
        s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
        if (s >= 9'd251) s = s - 9'd251;
        r[8*i +: 8] = s[7:0];
      end
    end
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.i_start) state_d = WAIT_EVAL;
      WAIT_EVAL: begin
        if (bus.i_eval_valid) begin
          if (cnt_q != '0)       state_d = MUL_ISSUE;
          else if (D_SPLIT == 1) state_d = DONE;
        end
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT:  if (bus.i_done_mul) state_d = ADD;
      ADD: begin
        if (t_q != LAST_T)             state_d = MUL_ISSUE;
        else if (cnt_q == LAST_CHUNK)  state_d = DONE;
        else                           state_d = WAIT_EVAL;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < T; i++) begin
        acc_q[i]  <= '0;
        w_q[i]    <= '0;
        pend_q[i] <= '0;
      end
      prod_q   <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            for (int i = 0; i < T; i++) w_q[i] <= bus.i_rpow[32*i +: 32];
            cnt_q <= '0;
          end
        end
        WAIT_EVAL: begin
          if (bus.i_eval_valid) begin
            if (cnt_q == '0) begin
              for (int i = 0; i < T; i++) acc_q[i] <= bus.i_eval[32*i +: 32];
              cnt_q <= cnt_q + 1'b1;
            end else begin
              for (int i = 0; i < T; i++) pend_q[i] <= bus.i_eval[32*i +: 32];
              t_q <= '0;
            end
          end
        end
        MUL_WAIT: if (bus.i_done_mul) prod_q <= bus.i_o_mul;
        ADD: begin
          acc_q[t_q] <= fadd(prod_q, pend_q[t_q]);
          if (t_q == LAST_T) cnt_q <= cnt_q + 1'b1;
          else               t_q   <= t_q + 1'b1;
        end
        DONE: begin
          for (int i = 0; i < T; i++) result_q[32*i +: 32] <= acc_q[i];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operands stay on the port from issue until the product returns, zero otherwise.
  always_comb begin
    bus.o_ready     = 1'b0;
    bus.o_start_mul = 1'b0;
    bus.o_x_mul     = '0;
    bus.o_y_mul     = '0;
    case (state_q)
      WAIT_EVAL: bus.o_ready = 1'b1;
      MUL_ISSUE: begin
        bus.o_start_mul = 1'b1;
        bus.o_x_mul     = acc_q[t_q];
        bus.o_y_mul     = w_q[t_q];
      end
      MUL_WAIT: begin
        bus.o_x_mul = acc_q[t_q];
        bus.o_y_mul = w_q[t_q];
      end
      default: ;
    endcase
  end

  assign bus.o_result = result_q;
  assign bus.o_done   = done_q;
endmodule
